cp0_except_unit: RTL and testbench

// - Coprocessor-0 register file plus precise-exception resolver for the 5-stage MIPS pipeline.
// - Consumes the exception flags that the main controller classifies in decode (syscall/break/invalid/eret),

---
 rtl/cp0_except_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_cp0_except_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_except_unit.sv
// Coprocessor-0 register file and precise-exception resolver for the M stage.
// Holds Status/Cause/EPC/BadVAddr/Count/Compare and drives the pipeline flush and redirect PC.
module cp0_except_unit #(
  parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  ext_int,
  input  logic        instr_validM,
  input  logic [31:0] pcM,
  input  logic        is_dsM,
  input  logic [31:0] bad_addrM,
  input  logic        adel_ifM,
  input  logic        adelM,
  input  logic        adesM,
  input  logic        syscallM,
  input  logic        breakM,
  input  logic        invalidM,
  input  logic        overflowM,
  input  logic        eretM,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush_except,
  output logic [31:0] newpc,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_STATUS   = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;

  typedef enum logic {S_RUN, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        tick_q, tick_d;

  logic        int_pend;
  logic        m_valid;
  logic        exc_take;
  logic        do_eret;
  logic [4:0]  exc_code;
  logic        set_bad;
  logic [31:0] bad_val;
  logic        ti_next;

  assign int_pend = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
  assign m_valid  = instr_validM & (state_q == S_RUN);

  // Priority resolver; eret sits between Bp and the data-side address errors.
  always_comb begin
    exc_take = 1'b0;
    do_eret  = 1'b0;
    exc_code = '0;
    set_bad  = 1'b0;
    bad_val  = '0;
    if (m_valid) begin
      if (int_pend) begin
        exc_take = 1'b1;
        exc_code = EXC_INT;
      end else if (adel_ifM) begin
        exc_take = 1'b1;
        exc_code = EXC_ADEL;
        set_bad  = 1'b1;
        bad_val  = pcM;
      end else if (invalidM) begin
        exc_take = 1'b1;
        exc_code = EXC_RI;
      end else if (overflowM) begin
        exc_take = 1'b1;
        exc_code = EXC_OV;
      end else if (syscallM) begin
        exc_take = 1'b1;
        exc_code = EXC_SYS;
      end else if (breakM) begin
        exc_take = 1'b1;
        exc_code = EXC_BP;
      end else if (eretM) begin
        do_eret = 1'b1;
      end else if (adelM) begin
        exc_take = 1'b1;
        exc_code = EXC_ADEL;
        set_bad  = 1'b1;
        bad_val  = bad_addrM;
      end else if (adesM) begin
        exc_take = 1'b1;
        exc_code = EXC_ADES;
        set_bad  = 1'b1;
        bad_val  = bad_addrM;
      end
    end
  end

  always_comb begin
    flush_except = exc_take | do_eret;
    newpc        = '0;
    if (do_eret) begin
      newpc = epc_q;
    end else if (exc_take) begin
      newpc = EXC_ENTRY;
    end
  end

  always_comb begin
    state_d = S_RUN;
    case (state_q)
      S_RUN:   state_d = flush_except ? S_HOLD : S_RUN;
      S_HOLD:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Register update: mtc0 first, then the exception overrides the fields it owns.
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q + {31'b0, tick_q};
    compare_d  = compare_q;
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    tick_d     = ~tick_q;

    ti_next = cause_q[30];
    if ((count_q == compare_q) && (compare_q != '0)) begin
      ti_next = 1'b1;
    end

    if (cp0_we) begin
      case (cp0_waddr)
        R_BADVADDR: badvaddr_d = cp0_wdata;
        R_COUNT:    count_d    = cp0_wdata;
        R_COMPARE: begin
          compare_d = cp0_wdata;
          ti_next   = 1'b0;
        end
        R_STATUS:   status_d     = (status_q & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
        R_CAUSE:    cause_d[9:8] = cp0_wdata[9:8];
        R_EPC:      epc_d        = cp0_wdata;
        default: ;
      endcase
    end

    cause_d[30]    = ti_next;
    cause_d[15:10] = {ext_int[5] | ti_next, ext_int[4:0]};

    if (exc_take) begin
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
      cause_d[31]   = is_dsM;
      epc_d         = is_dsM ? (pcM - 32'd4) : pcM;
      if (set_bad) begin
        badvaddr_d = bad_val;
      end
    end
    if (do_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RST;
      cause_q    <= '0;
      epc_q      <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      R_BADVADDR: cp0_rdata = badvaddr_q;
      R_COUNT:    cp0_rdata = count_q;
      R_COMPARE:  cp0_rdata = compare_q;
      R_STATUS:   cp0_rdata = status_q;
      R_CAUSE:    cp0_rdata = cause_q;
      R_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = '0;
    endcase
  end

  assign epc_o     = epc_q;
  assign status_o  = status_q;
  assign cause_o   = cause_q;
  assign timer_int = cause_q[30];

endmodule

// File: tb/tb_cp0_except_unit.sv
// Directed bench for cp0_except_unit: register access, timer, exception priority, eret and reset.
module tb_cp0_except_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  ext_int;
  logic        instr_validM;
  logic [31:0] pcM;
  logic        is_dsM;
  logic [31:0] bad_addrM;
  logic        adel_ifM, adelM, adesM, syscallM, breakM, invalidM, overflowM, eretM;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush_except;
  logic [31:0] newpc;
  logic [31:0] epc_o, status_o, cause_o;
  logic        timer_int;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rv;

  cp0_except_unit #(
    .EXC_ENTRY (32'hBFC0_0380),
    .STATUS_RST(32'h0040_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ext_int     (ext_int),
    .instr_validM(instr_validM),
    .pcM         (pcM),
    .is_dsM      (is_dsM),
    .bad_addrM   (bad_addrM),
    .adel_ifM    (adel_ifM),
    .adelM       (adelM),
    .adesM       (adesM),
    .syscallM    (syscallM),
    .breakM      (breakM),
    .invalidM    (invalidM),
    .overflowM   (overflowM),
    .eretM       (eretM),
    .cp0_we      (cp0_we),
    .cp0_waddr   (cp0_waddr),
    .cp0_wdata   (cp0_wdata),
    .cp0_raddr   (cp0_raddr),
    .cp0_rdata   (cp0_rdata),
    .flush_except(flush_except),
    .newpc       (newpc),
    .epc_o       (epc_o),
    .status_o    (status_o),
    .cause_o     (cause_o),
    .timer_int   (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_m();
    instr_validM = 1'b0;
    is_dsM = 1'b0;
    adel_ifM = 1'b0; adelM = 1'b0; adesM = 1'b0; syscallM = 1'b0;
    breakM = 1'b0; invalidM = 1'b0; overflowM = 1'b0; eretM = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    step();
    cp0_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_raddr = a;
    #1;
    d = cp0_rdata;
  endtask

  initial begin
    rst = 1'b0;
    ext_int = '0;
    pcM = '0; bad_addrM = '0;
    cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
    clear_m();
    repeat (2) @(posedge clk);
    #1;

    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_flush", {31'b0, flush_except}, 32'h0);
    check("rst_newpc", newpc, 32'h0);
    check("rst_ti", {31'b0, timer_int}, 32'h0);
    rd(5'd9, rv);  check("rst_count", rv, 32'h0);
    rd(5'd8, rv);  check("rst_badv", rv, 32'h0);

    // Timer: Count = floor(edges/2) from reset release.
    rst = 1'b1;
    mtc0(5'd11, 32'd4);
    repeat (7) step();
    rd(5'd9, rv);  check("tmr_count4", rv, 32'd4);
    check("tmr_ti_before", {31'b0, timer_int}, 32'h0);
    step();
    check("tmr_ti_set", {31'b0, timer_int}, 32'h1);
    check("tmr_cause", cause_o, 32'h4000_8000);
    rd(5'd11, rv); check("tmr_compare", rv, 32'd4);
    mtc0(5'd11, 32'd100);
    check("tmr_ti_clr", {31'b0, timer_int}, 32'h0);
    check("tmr_cause_clr", cause_o, 32'h0);
    step();
    mtc0(5'd9, 32'h10);
    rd(5'd9, rv);  check("count_wr_beats_inc", rv, 32'h10);

    mtc0(5'd12, 32'hFFFF_FFFF);
    check("status_mask", status_o, 32'h0040_FF03);
    mtc0(5'd12, 32'h0);
    check("status_clr", status_o, 32'h0040_0000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_mask", cause_o, 32'h0000_0300);
    mtc0(5'd13, 32'h0);
    mtc0(5'd15, 32'hFFFF_FFFF);
    rd(5'd15, rv); check("unimpl_rd", rv, 32'h0);

    // syscall
    instr_validM = 1'b1; syscallM = 1'b1; pcM = 32'h8000_0100;
    #1;
    check("sys_flush", {31'b0, flush_except}, 32'h1);
    check("sys_newpc", newpc, 32'hBFC0_0380);
    step();
    check("sys_epc", epc_o, 32'h8000_0100);
    check("sys_code", {27'b0, cause_o[6:2]}, 32'h08);
    check("sys_exl", {31'b0, status_o[1]}, 32'h1);
    check("sys_hold_noflush", {31'b0, flush_except}, 32'h0);
    clear_m();
    step();

    // AdES in delay slot
    instr_validM = 1'b1; adesM = 1'b1; is_dsM = 1'b1;
    pcM = 32'h8000_0204; bad_addrM = 32'h0000_1003;
    #1;
    check("ades_flush", {31'b0, flush_except}, 32'h1);
    step();
    check("ades_epc", epc_o, 32'h8000_0200);
    check("ades_bd", {31'b0, cause_o[31]}, 32'h1);
    check("ades_code", {27'b0, cause_o[6:2]}, 32'h05);
    rd(5'd8, rv);  check("ades_badv", rv, 32'h0000_1003);
    clear_m();
    step();

    // eret, then syscall in HOLD is ignored
    mtc0(5'd14, 32'h8000_0300);
    instr_validM = 1'b1; eretM = 1'b1;
    #1;
    check("eret_flush", {31'b0, flush_except}, 32'h1);
    check("eret_newpc", newpc, 32'h8000_0300);
    step();
    check("eret_exl", {31'b0, status_o[1]}, 32'h0);
    check("eret_cause_kept", cause_o, 32'h8000_0014);
    eretM = 1'b0; syscallM = 1'b1; pcM = 32'h8000_0900;
    #1;
    check("hold_sys_noflush", {31'b0, flush_except}, 32'h0);
    step();
    check("hold_sys_epc", epc_o, 32'h8000_0300);
    clear_m();

    // Interrupt
    mtc0(5'd12, 32'h0000_0401);
    check("int_status", status_o, 32'h0040_0401);
    ext_int = 6'b000001;
    step();
    check("int_ip2", {31'b0, cause_o[10]}, 32'h1);
    check("int_novalid", {31'b0, flush_except}, 32'h0);
    instr_validM = 1'b1; pcM = 32'h8000_0500;
    #1;
    check("int_flush", {31'b0, flush_except}, 32'h1);
    check("int_newpc", newpc, 32'hBFC0_0380);
    step();
    check("int_code", {27'b0, cause_o[6:2]}, 32'h00);
    check("int_epc", epc_o, 32'h8000_0500);
    step();
    check("int_exl_masked", {31'b0, flush_except}, 32'h0);
    ext_int = '0;
    clear_m();
    step();

    // Priority: RI beats Ov
    instr_validM = 1'b1; invalidM = 1'b1; overflowM = 1'b1; pcM = 32'h8000_0600;
    step();
    check("ri_over_ov", {27'b0, cause_o[6:2]}, 32'h0A);
    clear_m();
    step();

    // Priority: fetch AdEL beats RI and data AdEL, BadVAddr = pcM
    instr_validM = 1'b1; adel_ifM = 1'b1; invalidM = 1'b1; adelM = 1'b1;
    pcM = 32'h8000_0601; bad_addrM = 32'h0000_2222;
    step();
    check("adelif_code", {27'b0, cause_o[6:2]}, 32'h04);
    rd(5'd8, rv);  check("adelif_badv", rv, 32'h8000_0601);
    clear_m();
    step();

    // Priority: eret beats data AdEL
    instr_validM = 1'b1; eretM = 1'b1; adelM = 1'b1; bad_addrM = 32'h0000_3333;
    #1;
    check("eret_over_adel", newpc, 32'h8000_0601);
    step();
    rd(5'd8, rv);  check("eret_badv_kept", rv, 32'h8000_0601);
    clear_m();
    step();

    // mtc0 EPC and exception in the same cycle: exception owns EPC
    instr_validM = 1'b1; syscallM = 1'b1; pcM = 32'h8000_0400;
    mtc0(5'd14, 32'h0000_1234);
    check("mtc0_vs_exc_epc", epc_o, 32'h8000_0400);
    clear_m();
    step();

    // mtc0 Status and exception together: write lands, EXL forced
    instr_validM = 1'b1; breakM = 1'b1; pcM = 32'h8000_0410;
    mtc0(5'd12, 32'h0000_FF00);
    check("mtc0_vs_exc_status", status_o, 32'h0040_FF02);
    check("bp_code", {27'b0, cause_o[6:2]}, 32'h09);
    clear_m();

    // Reset mid-HOLD
    instr_validM = 1'b1; syscallM = 1'b1; pcM = 32'h8000_0700;
    step();
    rst = 1'b0;
    #2;
    check("rst2_status", status_o, 32'h0040_0000);
    check("rst2_epc", epc_o, 32'h0);
    check("rst2_cause", cause_o, 32'h0);
    rd(5'd11, rv); check("rst2_compare", rv, 32'h0);
    step();
    rst = 1'b1;
    #1;
    check("rst2_state_run", {31'b0, flush_except}, 32'h1);
    clear_m();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
